// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: issue FSM states, FIFO entry layout and the
// word-address compare used by load/store forwarding (STORE_BUF_FWD_EN).
package store_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } sb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } sb_entry_t;

  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order storage for pending stores: pointers, occupancy count and, when
// STORE_BUF_FWD_EN is defined, per-entry valid bits with a load-address hit check.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
`ifdef STORE_BUF_FWD_EN
  input  logic [31:0]      ld_addr,
  output logic             hit,
`endif
  output sb_entry_t        head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  sb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

`ifdef STORE_BUF_FWD_EN
  logic [DEPTH-1:0] valid_q;

  // Push never targets the popped slot: push needs !full, pop needs !empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (push) valid_q[wr_ptr_q] <= 1'b1;
      if (pop)  valid_q[rd_ptr_q] <= 1'b0;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && word_match(mem_q[i].addr, ld_addr)) hit = 1'b1;
    end
  end
`endif

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write queue between MEM and the AXI write adapter; issues one store at a
// time and retires it on mem_write_valid. STORE_BUF_FWD_EN enables address-precise
// ld_conflict instead of stalling every load while stores are pending.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_we,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_sel,
  output logic        st_stall,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        sb_empty,
  output logic        we,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic [3:0]  select,
  input  logic        mem_write_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  sb_state_e      state_q, state_d;
  sb_entry_t      head;
  logic [PTR_W:0] count;
  logic           full, empty, push, pop, issue;

  assign push = st_we && !full;

`ifdef STORE_BUF_FWD_EN
  logic hit;
`endif

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{addr: st_addr, data: st_data, sel: st_sel}),
    .pop        (pop),
`ifdef STORE_BUF_FWD_EN
    .ld_addr    (ld_addr),
    .hit        (hit),
`endif
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          issue   = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // Head stays queued until the adapter reports completion.
        if (mem_write_valid) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      we      <= 1'b0;
      address <= '0;
      data    <= '0;
      select  <= '0;
    end else begin
      state_q <= state_d;
      we      <= issue;
      if (issue) begin
        address <= head.addr;
        data    <= head.data;
        select  <= head.sel;
      end
    end
  end

  assign st_stall = full;
  assign sb_empty = empty && (state_q == StIdle);

`ifdef STORE_BUF_FWD_EN
  assign ld_conflict = hit;
`else
  assign ld_conflict = !sb_empty;
`endif

  // Count is observable only through full/empty; keep it for debug visibility.
  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based transaction model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, st_we, mem_write_valid;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [3:0]  st_sel;
  logic        st_stall, ld_conflict, sb_empty, we;
  logic [31:0] address, data;
  logic [3:0]  select;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .st_we           (st_we),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_sel          (st_sel),
    .st_stall        (st_stall),
    .ld_addr         (ld_addr),
    .ld_conflict     (ld_conflict),
    .sb_empty        (sb_empty),
    .we              (we),
    .address         (address),
    .data            (data),
    .select          (select),
    .mem_write_valid (mem_write_valid)
  );

  always #5 clk = ~clk;

  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending stores in order, plus the one handed to the adapter.
  logic [31:0] qa[$], qd[$];
  logic [3:0]  qs[$];
  bit          busy;
  int          age;
  bit          m_we, prev_we;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_sel;

  task automatic model_edge();
    bit do_pop, do_issue, do_push;
    if (reset) begin
      qa.delete(); qd.delete(); qs.delete();
      busy = 0; age = 0; m_we = 0;
      m_addr = '0; m_data = '0; m_sel = '0;
      return;
    end
    do_pop   = busy && age >= 1 && mem_write_valid;
    do_issue = !busy && qa.size() > 0;
    do_push  = st_we && qa.size() < DEPTH;
    m_we     = do_issue;
    if (do_issue) begin
      m_addr = qa[0]; m_data = qd[0]; m_sel = qs[0];
      busy = 1; age = 0;
    end else if (busy) begin
      if (do_pop) begin
        void'(qa.pop_front()); void'(qd.pop_front()); void'(qs.pop_front());
        busy = 0;
      end else begin
        age++;
      end
    end
    if (do_push) begin
      qa.push_back(st_addr); qd.push_back(st_data); qs.push_back(st_sel);
    end
  endtask

  task automatic check_outputs();
    bit exp_empty, exp_conf;
    exp_empty = (qa.size() == 0) && !busy;
`ifdef STORE_BUF_FWD_EN
    exp_conf = 0;
    foreach (qa[i]) if (qa[i][31:2] == ld_addr[31:2]) exp_conf = 1;
`else
    exp_conf = !exp_empty;
`endif
    check("we", 32'(we), 32'(m_we));
    check("address", address, m_addr);
    check("data", data, m_data);
    check("select", 32'(select), 32'(m_sel));
    check("st_stall", 32'(st_stall), 32'(qa.size() == DEPTH));
    check("sb_empty", 32'(sb_empty), 32'(exp_empty));
    check("ld_conflict", 32'(ld_conflict), 32'(exp_conf));
    check("we_back_to_back", 32'(we && prev_we), 32'(0));
    prev_we = we;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h2000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
  endfunction

  task automatic drive(input int p_we, input int p_rsp, input int p_rst);
    reset           = ($urandom_range(0, 999) < p_rst);
    st_we           = ($urandom_range(0, 99) < p_we);
    st_addr         = rand_addr();
    st_data         = $urandom;
    st_sel          = 4'($urandom_range(1, 15));
    ld_addr         = rand_addr();
    mem_write_valid = ($urandom_range(0, 99) < p_rsp);
  endtask

  initial begin
    int p_we[4]  = '{30, 90, 80, 10};
    int p_rsp[4] = '{60, 10, 50, 90};
    reset = 1'b1; st_we = 0; st_addr = '0; st_data = '0; st_sel = '0;
    ld_addr = '0; mem_write_valid = 0; prev_we = 0;
    busy = 0; age = 0; m_we = 0; m_addr = '0; m_data = '0; m_sel = '0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int cyc = 0; cyc < 800; cyc++) begin
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (ph == 0 && cyc == 0) reset = 1'b1;
        else drive(p_we[ph], p_rsp[ph], 7);
      end
    end
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
